// File: rtl/shm_ring_pkg.sv
// Shared definitions for the shared-RAM ring reader: bus widths, FSM states,
// and the ring index width helper.
package shm_ring_pkg;

  localparam int unsigned SHM_AW = 15;
  localparam int unsigned SHM_DW = 16;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    RD_HEAD,
    LAT_HEAD,
    CHECK,
    RD_DATA,
    LAT_DATA,
    OUT,
    WR_TAIL
  } state_e;

  // Bits needed to index a ring of 'words' slots (words is a power of two).
  function automatic int unsigned idx_width(input int unsigned words);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < words) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/shm_poll_timer.sv
// Loadable down-counter that spaces out head polls while the ring is empty.
module shm_poll_timer #(
  parameter int unsigned GAP = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [15:0] cnt_q, cnt_d;

  // Load to GAP-1 so the counting state lasts exactly GAP cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 16'(GAP - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/shm_ring_reader.sv
// Consumer of the ARM->fluid command ring in the shared dual-port RAM.
// Polls the producer head, streams new words out over valid/ready and
// writes the tail index back for space reclaim.
// Optional: define SHM_RING_READER_HEAD_CHECK_EN to flag out-of-range heads
// on head_err (ring treated as empty); otherwise the head is masked.
module shm_ring_reader
  import shm_ring_pkg::*;
#(
  parameter logic [SHM_AW-1:0] RING_BASE  = 15'h7000,
  parameter int unsigned       RING_WORDS = 1024,
  parameter logic [SHM_AW-1:0] HEAD_ADDR  = 15'h6FFE,
  parameter logic [SHM_AW-1:0] TAIL_ADDR  = 15'h6FFF,
  parameter int unsigned       POLL_GAP   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [SHM_AW-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [1:0]        mem_byteenable,
  output logic [SHM_DW-1:0] mem_writedata,
  input  logic [SHM_DW-1:0] mem_readdata,
  output logic [SHM_DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              head_err
);

  localparam int unsigned IW = idx_width(RING_WORDS);

  state_e            state_q, state_d;
  logic [IW-1:0]     tail_q, tail_d;
  logic [IW-1:0]     head_q, head_d;
  logic [SHM_DW-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [SHM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [SHM_DW-1:0] mem_wdata_q, mem_wdata_d;
  logic              timer_load;
  logic              poll_expire;
`ifdef SHM_RING_READER_HEAD_CHECK_EN
  logic              head_err_q, head_err_d;
`endif

  shm_poll_timer #(.GAP(POLL_GAP)) u_poll_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (timer_load),
    .en_i     (state_q == IDLE),
    .expire_o (poll_expire)
  );

  // Next-state, datapath and bus-command decode. Bus strobes are registered
  // from state_d so they sit in the access state's cycle yet read 0 in reset;
  // INIT therefore spends one cycle arming its tail write before issuing it.
  always_comb begin
    state_d     = state_q;
    tail_d      = tail_q;
    head_d      = head_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef SHM_RING_READER_HEAD_CHECK_EN
    head_err_d  = head_err_q;
`endif
    unique case (state_q)
      INIT:     if (mem_cs_q) state_d = IDLE;
      IDLE:     if (poll_expire && enable) state_d = RD_HEAD;
      RD_HEAD:  state_d = LAT_HEAD;
      LAT_HEAD: begin
        head_d = mem_readdata[IW-1:0];
`ifdef SHM_RING_READER_HEAD_CHECK_EN
        if (32'(mem_readdata) >= RING_WORDS) begin
          head_err_d = 1'b1;
          head_d     = tail_q;
        end
`endif
        state_d = CHECK;
      end
      CHECK:    state_d = (head_q == tail_q) ? IDLE : RD_DATA;
      RD_DATA:  state_d = LAT_DATA;
      LAT_DATA: begin
        out_data_d  = mem_readdata;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          tail_d      = tail_q + IW'(1);
          out_valid_d = 1'b0;
          state_d     = WR_TAIL;
        end
      end
      WR_TAIL:  state_d = (enable && (tail_q != head_q)) ? RD_DATA : IDLE;
      default:  state_d = INIT;
    endcase

    timer_load = (state_d == IDLE) && (state_q != IDLE);

    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_d)
      INIT: begin
        mem_cs_d   = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = TAIL_ADDR;
      end
      RD_HEAD: begin
        mem_cs_d   = 1'b1;
        mem_addr_d = HEAD_ADDR;
      end
      RD_DATA: begin
        mem_cs_d   = 1'b1;
        mem_addr_d = RING_BASE + SHM_AW'(tail_d);
      end
      WR_TAIL: begin
        mem_cs_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = TAIL_ADDR;
        mem_wdata_d = SHM_DW'(tail_d);
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      tail_q      <= '0;
      head_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tail_q      <= tail_d;
      head_q      <= head_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef SHM_RING_READER_HEAD_CHECK_EN
  // Sticky out-of-range head flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) head_err_q <= 1'b0;
    else       head_err_q <= head_err_d;
  end
  assign head_err = head_err_q;
`else
  assign head_err = 1'b0;
`endif

  assign mem_address    = mem_addr_q;
  assign mem_chipselect = mem_cs_q;
  assign mem_write      = mem_we_q;
  assign mem_byteenable = 2'b11;
  assign mem_writedata  = mem_wdata_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;

endmodule

// File: tb/tb_shm_ring_reader.sv
// Directed self-checking bench for shm_ring_reader with a registered-read
// RAM model and bus/stream monitors.
module tb_shm_ring_reader;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [14:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_writedata;
  logic [15:0] mem_readdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        head_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] ram [0:32767];

  typedef struct {
    int          cyc;
    logic        we;
    logic [14:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t        acc_q[$];
  logic [15:0] out_q[$];
  int          oacc_cyc_q[$];

  shm_ring_reader #(
    .RING_BASE  (15'h7000),
    .RING_WORDS (1024),
    .HEAD_ADDR  (15'h6FFE),
    .TAIL_ADDR  (15'h6FFF),
    .POLL_GAP   (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .head_err       (head_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_chipselect && !mem_write) mem_readdata <= ram[mem_address];
  end

  always @(negedge clk) begin
    if (mem_chipselect)
      acc_q.push_back('{cyc, mem_write, mem_address, mem_write ? mem_writedata : 16'h0});
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      oacc_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic we, input logic [14:0] addr, input logic [15:0] data);
    return {we, addr, data};
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_q.size()) return pk(acc_q[i].we, acc_q[i].addr, acc_q[i].data);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < acc_q.size()) return acc_q[i].cyc;
    return -1000;
  endfunction

  function automatic logic [15:0] out_at(input int i);
    if (i < out_q.size()) return out_q[i];
    return 16'hDEAD;
  endfunction

  function automatic int ocyc_at(input int i);
    if (i < oacc_cyc_q.size()) return oacc_cyc_q[i];
    return -1000;
  endfunction

  task automatic clear_logs();
    acc_q.delete();
    out_q.delete();
    oacc_cyc_q.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check("rst_cs",    {31'd0, mem_chipselect}, 32'd0);
    check("rst_we",    {31'd0, mem_write},      32'd0);
    check("rst_addr",  {17'd0, mem_address},    32'd0);
    check("rst_wdata", {16'd0, mem_writedata},  32'd0);
    check("rst_valid", {31'd0, out_valid},      32'd0);
    check("rst_data",  {16'd0, out_data},       32'd0);
    check("rst_err",   {31'd0, head_err},       32'd0);
    check("rst_be",    {30'd0, mem_byteenable}, 32'd3);
    @(negedge clk);
    clear_logs();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (acc_q.size() < n) check({tag, "_acc_timeout"}, acc_q.size(), n);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k = 0;
    while (!out_valid && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (!out_valid) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_tail(input logic [15:0] val, input int budget, input string tag);
    int  k = 0;
    bit  seen = 0;
    while (!seen && k < budget) begin
      @(negedge clk); #1;
      k++;
      if (acc_q.size() > 0)
        seen = acc_q[$].we && (acc_q[$].addr == 15'h6FFF) && (acc_q[$].data == val);
    end
    if (!seen) check({tag, "_tail_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp2 [9];
    logic [31:0] exp3 [5];
    int          n0;
    bit          stable;
    int          hi_reads;

    reset = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 32768; i++) ram[i] = 16'h0;

    // Reset release: one tail clear, then a head poll POLL_GAP idle cycles later
    ram[15'h6FFE] = 16'h0000;
    apply_reset();
    wait_acc(2, 60, "t1");
    check("t1_init_wr", acc_at(0), pk(1'b1, 15'h6FFF, 16'h0));
    check("t1_poll",    acc_at(1), pk(1'b0, 15'h6FFE, 16'h0));
    check("t1_gap",     cyc_at(1) - cyc_at(0), 32'd17);

    // Three words, out_ready held high
    ram[15'h6FFE] = 16'd3;
    ram[15'h7000] = 16'hA001;
    ram[15'h7001] = 16'hA002;
    ram[15'h7002] = 16'hA003;
    exp2[0] = pk(1'b1, 15'h6FFF, 16'd0);
    exp2[1] = pk(1'b0, 15'h6FFE, 16'd0);
    exp2[2] = pk(1'b0, 15'h7000, 16'd0);
    exp2[3] = pk(1'b1, 15'h6FFF, 16'd1);
    exp2[4] = pk(1'b0, 15'h7001, 16'd0);
    exp2[5] = pk(1'b1, 15'h6FFF, 16'd2);
    exp2[6] = pk(1'b0, 15'h7002, 16'd0);
    exp2[7] = pk(1'b1, 15'h6FFF, 16'd3);
    exp2[8] = pk(1'b0, 15'h6FFE, 16'd0);
    apply_reset();
    wait_acc(9, 120, "t2");
    for (int i = 0; i < 9; i++) check($sformatf("t2_acc%0d", i), acc_at(i), exp2[i]);
    check("t2_nout",  out_q.size(), 32'd3);
    check("t2_w0",    {16'd0, out_at(0)}, 32'hA001);
    check("t2_w1",    {16'd0, out_at(1)}, 32'hA002);
    check("t2_w2",    {16'd0, out_at(2)}, 32'hA003);
    check("t2_lat",   ocyc_at(0) - cyc_at(1), 32'd5);
    check("t2_b2b",   ocyc_at(1) - ocyc_at(0), 32'd4);
    check("t2_repoll", cyc_at(8) - cyc_at(1), 32'd31);

    // Wrap: drain to tail 1023, producer moves head to 1
    ram[15'h6FFE] = 16'd1023;
    ram[15'h7000] = 16'hB000;
    ram[15'h73FF] = 16'hB3FF;
    apply_reset();
    wait_tail(16'd1023, 5000, "t3a");
    ram[15'h6FFE] = 16'd1;
    clear_logs();
    exp3[0] = pk(1'b0, 15'h6FFE, 16'd0);
    exp3[1] = pk(1'b0, 15'h73FF, 16'd0);
    exp3[2] = pk(1'b1, 15'h6FFF, 16'd0);
    exp3[3] = pk(1'b0, 15'h7000, 16'd0);
    exp3[4] = pk(1'b1, 15'h6FFF, 16'd1);
    wait_acc(5, 100, "t3");
    for (int i = 0; i < 5; i++) check($sformatf("t3_acc%0d", i), acc_at(i), exp3[i]);
    check("t3_w0", {16'd0, out_at(0)}, 32'hB3FF);
    check("t3_w1", {16'd0, out_at(1)}, 32'hB000);

    // Backpressure for 20 cycles
    ram[15'h6FFE] = 16'd1;
    ram[15'h7000] = 16'hC0DE;
    out_ready = 1'b0;
    apply_reset();
    wait_valid(100, "t4");
    n0 = acc_q.size();
    stable = 1;
    repeat (20) begin
      @(negedge clk); #1;
      if (!out_valid || out_data !== 16'hC0DE) stable = 0;
    end
    check("t4_stable", {31'd0, stable}, 32'd1);
    check("t4_noacc",  acc_q.size(), n0);
    check("t4_noacpt", out_q.size(), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk); #1;
    check("t4_accept", out_q.size(), 32'd1);
    check("t4_word",   {16'd0, out_at(0)}, 32'hC0DE);
    @(negedge clk); #1;
    check("t4_vdrop",  {31'd0, out_valid}, 32'd0);
    check("t4_tailwr", acc_at(acc_q.size() - 1), pk(1'b1, 15'h6FFF, 16'd1));

    // Head beyond the ring
    ram[15'h6FFE] = 16'h0500;
    for (int i = 0; i < 256; i++) ram[15'h7000 + i] = 16'hD000 + 16'(i);
    ram[15'h7100] = 16'hEEEE;
    apply_reset();
`ifdef SHM_RING_READER_HEAD_CHECK_EN
    wait_acc(3, 100, "t5");
    check("t5_poll2", acc_at(2), pk(1'b0, 15'h6FFE, 16'd0));
    check("t5_err",   {31'd0, head_err}, 32'd1);
    check("t5_nout",  out_q.size(), 32'd0);
`else
    wait_tail(16'h0100, 1500, "t5");
    check("t5_nout",  out_q.size(), 32'd256);
    check("t5_first", {16'd0, out_at(0)},   32'hD000);
    check("t5_last",  {16'd0, out_at(255)}, 32'hD0FF);
    check("t5_err",   {31'd0, head_err}, 32'd0);
    hi_reads = 0;
    foreach (acc_q[i])
      if (!acc_q[i].we && acc_q[i].addr >= 15'h7100 && acc_q[i].addr < 15'h7400) hi_reads++;
    check("t5_hireads", hi_reads, 32'd0);
`endif

    // Asynchronous reset while holding a word, then enable gating
    ram[15'h6FFE] = 16'd1;
    ram[15'h7000] = 16'hF00D;
    out_ready = 1'b0;
    apply_reset();
    wait_valid(100, "t6");
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, out_valid},      32'd0);
    check("t6_async_data",  {16'd0, out_data},       32'd0);
    check("t6_async_cs",    {31'd0, mem_chipselect}, 32'd0);
    enable = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    check("t6_nacc",   acc_q.size(), 32'd1);
    check("t6_initwr", acc_at(0), pk(1'b1, 15'h6FFF, 16'd0));
    check("t6_nout",   out_q.size(), 32'd0);
    enable = 1'b1;
    wait_acc(2, 20, "t6");
    check("t6_poll",   acc_at(1), pk(1'b0, 15'h6FFE, 16'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shm_ring_reader.md
# shm_ring_reader

Consumer stage on the secondary port (s2) of the fluid board's 16-bit, 32768-word dual-port shared on-chip RAM. The ARM side writes 16-bit command words into a ring region of that RAM and advances a head index. This block polls the head, reads each new word, and presents it as a valid/ready stream to the fluid control logic. It writes its tail index back so the producer can reclaim space.

## Interface
Parameters:
- RING_BASE, 15'h7000, word address of ring slot 0.
- RING_WORDS, 1024, ring depth in words; power of two, 2..4096.
- HEAD_ADDR, 15'h6FFE, word address of the producer head index.
- TAIL_ADDR, 15'h6FFF, word address of the consumer tail index.
- POLL_GAP, 16, idle cycles between head polls when the ring is empty; range 1..65535.

Ports:
- clk  in  1  single clock for everything; same clock as the RAM's clk.
- reset  in  1  asynchronous, active-high.
- enable  in  1  0 = finish the current word, then park in IDLE without polling.
- mem_address  out  15  word address to RAM port 2.
- mem_chipselect  out  1  access strobe.
- mem_write  out  1  1 = write, 0 = read; valid only with chipselect.
- mem_byteenable  out  2  constant 2'b11.
- mem_writedata  out  16  tail value, zero-extended.
- mem_readdata  in  16  RAM q_b; valid the cycle after a read strobe.
- out_data  out  16  command word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts.
- head_err  out  1  sticky; set when a polled head is >= RING_WORDS. Cleared only by reset.

## Operation
- Internal state: tail register (log2(RING_WORDS) bits), cached head, poll counter (16 bits).
- State machine:
  - INIT: write 0 to TAIL_ADDR, then go to IDLE.
  - IDLE: count POLL_GAP cycles. Enter RD_HEAD when the count expires and enable=1.
  - RD_HEAD: strobe a read of HEAD_ADDR.
  - LAT_HEAD: capture mem_readdata into the cached head.
  - CHECK:
    - cached head == tail -> IDLE (counter reloaded).
    - otherwise -> RD_DATA.
  - RD_DATA: strobe a read of RING_BASE + tail.
  - LAT_DATA: capture the word into out_data, assert out_valid, go to OUT.
  - OUT: hold out_data and out_valid until out_ready=1. On that cycle: tail <= (tail+1) mod RING_WORDS, then go to WR_TAIL.
  - WR_TAIL: write the new tail to TAIL_ADDR.
    - enable=1 and tail != cached head -> RD_DATA, with no re-poll.
    - otherwise -> IDLE.
- Wrap-around: tail wraps to 0 by masking the low bits. The ring is empty when head == tail. The producer is responsible for leaving one slot free.
- The cached head is re-read only from IDLE. Words the producer adds mid-batch are picked up on the next poll.
- enable deasserted mid-batch: the word in flight still completes through WR_TAIL, then the block goes to IDLE.
- Reset mid-operation: all registers clear and the block goes to INIT. Any word held in OUT is discarded, and the producer must re-initialise its head.
- Default (no macro): head is masked to its low log2(RING_WORDS) bits and head_err stays 0.

## Timing
- Outputs during reset: mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, out_valid=0, out_data=0, head_err=0. mem_byteenable=2'b11 at all times.
- mem_chipselect is high for exactly one cycle per access. The RAM registers the address at that clock edge; mem_readdata is sampled in the following cycle.
- Empty-ring detection to the first out_valid: RD_HEAD, LAT_HEAD, CHECK, RD_DATA, LAT_DATA = 5 cycles.
- Back-to-back words with out_ready held at 1: one word every 4 cycles (OUT, WR_TAIL, RD_DATA, LAT_DATA).
- out_data is stable while out_valid=1 && out_ready=0. out_valid drops the cycle after acceptance.

## Configuration
- SHM_RING_READER_HEAD_CHECK_EN defined:
  - A polled head >= RING_WORDS sets head_err.
  - The block treats the ring as empty and returns to IDLE.
- Undefined: the behaviour described in the last Operation bullet applies (head masked, head_err tied to 0).

## Structure
- Package shm_ring_pkg holds:
  - SHM_AW=15 and SHM_DW=16.
  - The state enum (INIT, IDLE, RD_HEAD, LAT_HEAD, CHECK, RD_DATA, LAT_DATA, OUT, WR_TAIL).
  - A function computing the masked index width from RING_WORDS.
- Sub-module shm_poll_timer: loadable down-counter. Inputs: load, enable. Output: expire pulse.

## Test plan
- Reset release: exactly one write of 0 to 15'h6FFF in INIT, then a read of 15'h6FFE after POLL_GAP idle cycles.
- Head=3 preloaded, out_ready=1: out_valid carries words from 0x7000, 0x7001, 0x7002 in order. Tail writes of 1, 2, 3 follow, then a return to IDLE.
- Tail=1023, head=1: the word at 0x73FF is output, then the word at 0x7000, and the tail writebacks are 0 then 1.
- out_ready held low for 20 cycles: out_data stable, no RAM access, no tail write. Acceptance occurs on the cycle out_ready rises.
- With the macro defined, head=0x0500: head_err=1, no data reads. Without the macro, the block reads slots up to masked head 0x100.
- Reset asserted while in OUT: out_valid=0 immediately (asynchronous), then the INIT tail write of 0 follows.
